psram_line_fetch: RTL and testbench



---
 rtl/psram_line_fetch_pkg.sv | 25 ++
 rtl/psram_line_fetch_addr.sv | 46 ++++
 rtl/psram_line_fetch.sv | 225 ++++++++++++++++++++++
 tb/tb_psram_line_fetch.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_line_fetch_pkg.sv
// rtl/psram_line_fetch_pkg.sv - shared types, colour constants and pixel expansion for psram_line_fetch
//
// Purpose : FSM state encoding, RGB565->RGB888 expansion and checkerboard
//           colours shared by psram_line_fetch and its sub-module.
// Ports   : none (package)
package psram_line_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DATA,
      DONE,
      PAT
   } state_t;

   localparam logic [23:0] PAT_DARK  = 24'h444444;
   localparam logic [23:0] PAT_LIGHT = 24'hEEEEEE;

   // Each channel's top bits are replicated into the new low bits so that
   // full-scale inputs map to 0xFF and zero stays 0x00.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction

endpackage

// File: rtl/psram_line_fetch_addr.sv
// rtl/psram_line_fetch_addr.sv - line base address register and burst address adder
//
// Purpose : Registers line_base = FB_BASE + y*H_RES when load is high and
//           presents line_base + x as the current burst start address.
//           All arithmetic wraps modulo 2^ADDR_W.
// Ports   : clk_psram, rst      clock / async active-high reset
//           load                capture a new line base from y_in
//           y_in[9:0]           line number
//           x[9:0]              pixel index of the burst start
//           addr[ADDR_W-1:0]    word address of the burst start
module line_addr_gen
   import psram_line_fetch_pkg::*;
#(
   parameter int H_RES   = 800,
   parameter int ADDR_W  = 22,
   parameter int FB_BASE = 0
) (
   input  logic              clk_psram,
   input  logic              rst,
   input  logic              load,
   input  logic [9:0]        y_in,
   input  logic [9:0]        x,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_d;

   always_comb begin
      base_d = base_q;
      if (load) begin
         base_d = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(FB_BASE);
      end
   end

   always_ff @(posedge clk_psram or posedge rst) begin
      if (rst) begin
         base_q <= '0;
      end else begin
         base_q <= base_d;
      end
   end

   assign addr = base_q + ADDR_W'(x);

endmodule

// File: rtl/psram_line_fetch.sv
// rtl/psram_line_fetch.sv - fetches one RGB565 scanline from PSRAM and writes it as RGB888 into the line buffer
//
// Purpose : On each rising edge of line_request, issues H_RES/BURST burst
//           reads starting at FB_BASE + y*H_RES, expands each returned beat
//           to RGB888 and writes it to the line buffer one cycle later.
//           Aborts with err_timeout if the response stream stalls for
//           TIMEOUT cycles; flags err_overrun on a request while busy.
// Config  : `define PSRAM_LINE_FETCH_PATTERN_EN adds pattern_sel, which makes
//           a request write a 16x16 checkerboard instead of fetching.
// Ports   : clk_psram, rst                  clock / async active-high reset
//           line_request, y_pos             level request and line number
//           pattern_sel                     (pattern build only) checkerboard select
//           cmd_valid/cmd_ready/cmd_addr    burst read command handshake
//           rsp_valid/rsp_data              RGB565 response beats
//           wr_en/wr_addr/wr_data           line buffer write port
//           busy, err_timeout, err_overrun  status
module psram_line_fetch
   import psram_line_fetch_pkg::*;
#(
   parameter int H_RES   = 800,
   parameter int BURST   = 16,
   parameter int ADDR_W  = 22,
   parameter int FB_BASE = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk_psram,
   input  logic              rst,
   input  logic              line_request,
   input  logic [9:0]        y_pos,
`ifdef PSRAM_LINE_FETCH_PATTERN_EN
   input  logic              pattern_sel,
`endif
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              rsp_valid,
   input  logic [15:0]       rsp_data,
   output logic [9:0]        wr_addr,
   output logic [23:0]       wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overrun
);

   localparam int BEAT_W = $clog2(BURST);
   localparam int TO_W   = $clog2(TIMEOUT + 1);

   state_t             state_q, state_d;
   logic               line_req_q;
   logic [9:0]         x_q, x_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic               busy_q, busy_d;
   logic               wr_en_q, wr_en_d;
   logic [9:0]         wr_addr_q, wr_addr_d;
   logic [23:0]        wr_data_q, wr_data_d;
   logic               err_timeout_q, err_timeout_d;
   logic               err_overrun_q, err_overrun_d;
   logic               load_base;
   logic               req_edge;
   logic [ADDR_W-1:0]  burst_addr;
`ifdef PSRAM_LINE_FETCH_PATTERN_EN
   logic               y4_q, y4_d;
`endif

   assign req_edge = line_request & ~line_req_q;

   line_addr_gen #(
      .H_RES   (H_RES),
      .ADDR_W  (ADDR_W),
      .FB_BASE (FB_BASE)
   ) u_addr (
      .clk_psram (clk_psram),
      .rst       (rst),
      .load      (load_base),
      .y_in      (y_pos),
      .x         (x_q),
      .addr      (burst_addr)
   );

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      beat_d        = beat_q;
      to_d          = to_q;
      busy_d        = busy_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      err_timeout_d = 1'b0;
      // Only IDLE accepts a request; any other state (DONE included) drops it.
      err_overrun_d = req_edge && (state_q != IDLE);
      load_base     = 1'b0;
`ifdef PSRAM_LINE_FETCH_PATTERN_EN
      y4_d          = y4_q;
`endif

      case (state_q)
         IDLE: begin
            if (req_edge) begin
               load_base = 1'b1;
               x_d       = '0;
               busy_d    = 1'b1;
               state_d   = CMD;
`ifdef PSRAM_LINE_FETCH_PATTERN_EN
               y4_d      = y_pos[4];
               if (pattern_sel) begin
                  state_d = PAT;
               end
`endif
            end
         end

         CMD: begin
            if (cmd_ready) begin
               beat_d  = '0;
               to_d    = '0;
               state_d = DATA;
            end
         end

         DATA: begin
            if (rsp_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = x_q;
               wr_data_d = rgb565_to_888(rsp_data);
               to_d      = '0;
               x_d       = x_q + 10'd1;
               beat_d    = beat_q + 1'b1;
               if (beat_q == BEAT_W'(BURST - 1)) begin
                  beat_d = '0;
                  if (x_q == 10'(H_RES - 1)) begin
                     x_d     = '0;
                     state_d = DONE;
                  end else begin
                     state_d = CMD;
                  end
               end
            end else if (to_q == TO_W'(TIMEOUT - 1)) begin
               // This idle cycle is the TIMEOUT-th in a row.
               err_timeout_d = 1'b1;
               busy_d        = 1'b0;
               x_d           = '0;
               beat_d        = '0;
               to_d          = '0;
               state_d       = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

`ifdef PSRAM_LINE_FETCH_PATTERN_EN
         PAT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = x_q;
            wr_data_d = (x_q[4] ^ y4_q) ? PAT_LIGHT : PAT_DARK;
            x_d       = x_q + 10'd1;
            if (x_q == 10'(H_RES - 1)) begin
               x_d     = '0;
               state_d = DONE;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_psram or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         line_req_q    <= 1'b0;
         x_q           <= '0;
         beat_q        <= '0;
         to_q          <= '0;
         busy_q        <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_req_q    <= line_request;
         x_q           <= x_d;
         beat_q        <= beat_d;
         to_q          <= to_d;
         busy_q        <= busy_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

`ifdef PSRAM_LINE_FETCH_PATTERN_EN
   always_ff @(posedge clk_psram or posedge rst) begin
      if (rst) begin
         y4_q <= 1'b0;
      end else begin
         y4_q <= y4_d;
      end
   end
`endif

   // The address is forced to zero outside CMD so the bus is quiet when idle.
   assign cmd_valid   = (state_q == CMD);
   assign cmd_addr    = cmd_valid ? burst_addr : '0;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = busy_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_psram_line_fetch.sv
// tb/tb_psram_line_fetch.sv - directed self-checking bench for psram_line_fetch
module tb_psram_line_fetch;

   localparam int H_RES   = 32;
   localparam int BURST   = 16;
   localparam int ADDR_W  = 22;
   localparam int FB_BASE = 'h100;
   localparam int TIMEOUT = 20;

   logic              clk_psram = 1'b0;
   logic              rst;
   logic              line_request;
   logic [9:0]        y_pos;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              rsp_valid;
   logic [15:0]       rsp_data;
   logic [9:0]        wr_addr;
   logic [23:0]       wr_data;
   logic              wr_en;
   logic              busy;
   logic              err_timeout;
   logic              err_overrun;
`ifdef PSRAM_LINE_FETCH_PATTERN_EN
   logic              pattern_sel = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] cmd_log[$];
   logic [9:0]        wa_log[$];
   logic [23:0]       wd_log[$];
   int                to_cnt = 0;
   int                ov_cnt = 0;

   psram_line_fetch #(
      .H_RES   (H_RES),
      .BURST   (BURST),
      .ADDR_W  (ADDR_W),
      .FB_BASE (FB_BASE),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_psram    (clk_psram),
      .rst          (rst),
      .line_request (line_request),
      .y_pos        (y_pos),
`ifdef PSRAM_LINE_FETCH_PATTERN_EN
      .pattern_sel  (pattern_sel),
`endif
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_addr     (cmd_addr),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .err_overrun  (err_overrun)
   );

   always #5 clk_psram = ~clk_psram;

   // Passive logging at the falling edge, away from the active edge.
   always @(negedge clk_psram) begin
      if (wr_en) begin
         wa_log.push_back(wr_addr);
         wd_log.push_back(wr_data);
      end
      if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_addr);
      if (err_timeout) to_cnt++;
      if (err_overrun) ov_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk_psram);
      #1;
   endtask

   function automatic logic [15:0] pix(input int mode, input int idx);
      if (mode == 0) return 16'(idx);
      case (idx)
         0: return 16'hF800;
         1: return 16'h07E0;
         2: return 16'h001F;
         3: return 16'h8410;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic request(input logic [9:0] y);
      y_pos        = y;
      line_request = 1'b1;
      step;
      line_request = 1'b0;
   endtask

   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_valid && cmd_ready) begin
            ok = 1'b1;
            break;
         end
         step;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL cmd_accept: cmd_valid=%0b cmd_ready=%0b, required an accept within 50 cycles", cmd_valid, cmd_ready);
      end
      step;
   endtask

   task automatic serve_burst(input int nb, input int start_idx, input int mode);
      bit ok;
      wait_accept(ok);
      for (int k = 0; k < nb; k++) begin
         rsp_valid = 1'b1;
         rsp_data  = pix(mode, start_idx + k);
         step;
      end
      rsp_valid = 1'b0;
      rsp_data  = 16'h0;
   endtask

   // Line written with rsp_data = pixel index: only B5 is non-zero.
   task automatic check_line(input string name, input int w0);
      logic [4:0]  b;
      logic [23:0] exp_d;
      n_checks++;
      if (wa_log.size() - w0 !== H_RES) begin
         n_fail++;
         $display("FAIL %s_write_count: got %0d, required %0d", name, wa_log.size() - w0, H_RES);
      end
      for (int i = 0; i < H_RES; i++) begin
         if (w0 + i < wa_log.size()) begin
            b     = i[4:0];
            exp_d = {16'h0000, b, b[4:2]};
            n_checks++;
            if (wa_log[w0+i] !== 10'(i) || wd_log[w0+i] !== exp_d) begin
               n_fail++;
               $display("FAIL %s_write_%0d: addr=%0d data=%h, required addr=%0d data=%h", name, i, wa_log[w0+i], wd_log[w0+i], i, exp_d);
            end
         end
      end
   endtask

   task automatic check_cmds(input string name, input int c0, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      n_checks++;
      if (cmd_log.size() - c0 !== 2) begin
         n_fail++;
         $display("FAIL %s_cmd_count: got %0d, required 2", name, cmd_log.size() - c0);
      end else begin
         n_checks++;
         if (cmd_log[c0] !== a0 || cmd_log[c0+1] !== a1) begin
            n_fail++;
            $display("FAIL %s_cmd_addr: got %h %h, required %h %h", name, cmd_log[c0], cmd_log[c0+1], a0, a1);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      step;
      n_checks++;
      if (cmd_valid !== 1'b0 || cmd_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_cmd: cmd_valid=%0b cmd_addr=%h, required 0 0", cmd_valid, cmd_addr);
      end
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 24'd0) begin
         n_fail++;
         $display("FAIL reset_wr: wr_en=%0b wr_addr=%0d wr_data=%h, required 0 0 0", wr_en, wr_addr, wr_data);
      end
      n_checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: busy=%0b err_timeout=%0b err_overrun=%0b, required 0 0 0", busy, err_timeout, err_overrun);
      end
      rst = 1'b0;
      step;
      n_checks++;
      if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%0b cmd_valid=%0b, required 0 0", busy, cmd_valid);
      end
   endtask

   task automatic test_basic_fetch;
      int w0 = wa_log.size();
      int c0 = cmd_log.size();
      cmd_ready = 1'b1;
      request(10'd3);
      serve_burst(16, 0, 0);
      serve_burst(16, 16, 0);
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'd31 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_last_write: wr_en=%0b wr_addr=%0d busy=%0b, required 1 31 1", wr_en, wr_addr, busy);
      end
      step;
      n_checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy_end: busy=%0b wr_en=%0b, required 0 0", busy, wr_en);
      end
      check_line("basic", w0);
      check_cmds("basic", c0, 22'h160, 22'h170);
   endtask

   task automatic test_colour;
      bit          ok;
      logic [23:0] exp_d;
      request(10'd0);
      wait_accept(ok);
      for (int k = 0; k < 16; k++) begin
         rsp_valid = 1'b1;
         rsp_data  = pix(1, k);
         step;
         case (k)
            0: exp_d = 24'hFF0000;
            1: exp_d = 24'h00FF00;
            2: exp_d = 24'h0000FF;
            3: exp_d = 24'h848284;
            default: exp_d = 24'h000000;
         endcase
         n_checks++;
         if (wr_en !== 1'b1 || wr_addr !== 10'(k) || wr_data !== exp_d) begin
            n_fail++;
            $display("FAIL colour_beat_%0d: wr_en=%0b wr_addr=%0d wr_data=%h, required 1 %0d %h", k, wr_en, wr_addr, wr_data, k, exp_d);
         end
      end
      rsp_valid = 1'b0;
      serve_burst(16, 16, 1);
      step;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL colour_busy_end: busy=%0b, required 0", busy);
      end
   endtask

   task automatic test_backpressure;
      int w0 = wa_log.size();
      int c0 = cmd_log.size();
      cmd_ready = 1'b0;
      request(10'd1);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (cmd_valid !== 1'b1 || cmd_addr !== 22'h120) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: cmd_valid=%0b cmd_addr=%h, required 1 120", i, cmd_valid, cmd_addr);
         end
         step;
      end
      n_checks++;
      if (cmd_log.size() - c0 !== 0) begin
         n_fail++;
         $display("FAIL bp_no_accept: got %0d accepts, required 0", cmd_log.size() - c0);
      end
      cmd_ready = 1'b1;
      serve_burst(16, 0, 0);
      serve_burst(16, 16, 0);
      step;
      step;
      check_line("bp", w0);
      check_cmds("bp", c0, 22'h120, 22'h130);
   endtask

   task automatic test_timeout;
      int w0 = wa_log.size();
      int c0 = cmd_log.size();
      int t0 = to_cnt;
      request(10'd2);
      serve_burst(5, 0, 0);
      for (int i = 0; i < 19; i++) step;
      n_checks++;
      if (err_timeout !== 1'b0 || to_cnt - t0 !== 0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_early: err_timeout=%0b pulses=%0d busy=%0b, required 0 0 1", err_timeout, to_cnt - t0, busy);
      end
      step;
      n_checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: err_timeout=%0b busy=%0b, required 1 0", err_timeout, busy);
      end
      step;
      n_checks++;
      if (err_timeout !== 1'b0 || to_cnt - t0 !== 1 || cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_after: err_timeout=%0b pulses=%0d cmd_valid=%0b, required 0 1 0", err_timeout, to_cnt - t0, cmd_valid);
      end
      n_checks++;
      if (wa_log.size() - w0 !== 5 || cmd_log.size() - c0 !== 1) begin
         n_fail++;
         $display("FAIL timeout_counts: writes=%0d cmds=%0d, required 5 1", wa_log.size() - w0, cmd_log.size() - c0);
      end
   endtask

   task automatic test_overrun;
      bit ok;
      int w0 = wa_log.size();
      int c0 = cmd_log.size();
      int o0 = ov_cnt;
      request(10'd4);
      wait_accept(ok);
      for (int k = 0; k < 16; k++) begin
         rsp_valid = 1'b1;
         rsp_data  = pix(0, k);
         if (k == 3) line_request = 1'b1;
         step;
         if (k == 3) begin
            n_checks++;
            if (err_overrun !== 1'b1) begin
               n_fail++;
               $display("FAIL overrun_pulse: err_overrun=%0b, required 1", err_overrun);
            end
         end
      end
      rsp_valid    = 1'b0;
      line_request = 1'b0;
      serve_burst(16, 16, 0);
      step;
      step;
      n_checks++;
      if (ov_cnt - o0 !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_count: pulses=%0d busy=%0b, required 1 0", ov_cnt - o0, busy);
      end
      check_line("overrun", w0);
      check_cmds("overrun", c0, 22'h180, 22'h190);
   endtask

   task automatic test_reset_mid_data;
      bit ok;
      int w0;
      int c0;
      request(10'd5);
      wait_accept(ok);
      for (int k = 0; k < 7; k++) begin
         rsp_valid = 1'b1;
         rsp_data  = pix(0, k);
         step;
      end
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'd6) begin
         n_fail++;
         $display("FAIL rstmid_pre: wr_en=%0b wr_addr=%0d, required 1 6", wr_en, wr_addr);
      end
      rsp_valid = 1'b0;
      rst       = 1'b1;
      #1;
      n_checks++;
      if (wr_en !== 1'b0 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_immediate: wr_en=%0b cmd_valid=%0b busy=%0b, required 0 0 0", wr_en, cmd_valid, busy);
      end
      step;
      rst = 1'b0;
      step;
      w0 = wa_log.size();
      c0 = cmd_log.size();
      request(10'd5);
      serve_burst(16, 0, 0);
      serve_burst(16, 16, 0);
      step;
      step;
      check_line("rstmid", w0);
      check_cmds("rstmid", c0, 22'h1A0, 22'h1B0);
   endtask

   initial begin
      rst          = 1'b1;
      line_request = 1'b0;
      y_pos        = 10'd0;
      cmd_ready    = 1'b0;
      rsp_valid    = 1'b0;
      rsp_data     = 16'h0;
      test_reset;
      test_basic_fetch;
      test_colour;
      test_backpressure;
      test_timeout;
      test_overrun;
      test_reset_mid_data;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
